seven_seg_scan_decoder: RTL and testbench
=========================================

// Module: seven_seg_scan_decoder
// PURPOSE
//  Reads a multiplexed, common-anode 7-segment display bus and decodes it back to hex digits.
//  It is the inverse of the hex->segment encoder. It watches the active-low segment and
//  digit-enable lines, captures each digit once its pattern has settled, and assembles a frame.
//  It presents the frame on a valid/ready port. Used for display self-check and for scoreboarding.
// PARAMETERS
//  NUM_DIGITS     4  number of scanned digits; an_i bit k selects digit k (digit k = value_o[4k+3:4k])
//  STABLE_CYCLES  4  consecutive identical samples required before a digit is captured (>=2)
// PORTS
//  clk        in   1             system clock, rising edge
//  rst        in   1             synchronous reset, active-high
//  seg_i      in   7             segment bus {g,f,e,d,c,b,a}, active-low (common anode)
//  an_i       in   NUM_DIGITS    digit enables, active-low; exactly one low = legal select
//  value_o    out  4*NUM_DIGITS  decoded frame, one hex nibble per digit
//  blank_o    out  NUM_DIGITS    per digit: pattern was 7'h7F (all segments off)
//  err_o      out  NUM_DIGITS    per digit: pattern not in the 17-entry table
//  valid_o    out  1             frame available
//  ready_i    in   1             consumer accepts frame when valid_o & ready_i
//  overrun_o  out  1             1-cycle pulse: frame completed while previous frame still unaccepted
// BEHAVIOUR
//  - Reset: value_o=0, blank_o=0, err_o=0, valid_o=0, overrun_o=0, seen mask=0, counter=0, FSM=WAIT.
//  - Inputs are registered once: seg_q, an_q. All checks use the registered values.
//    Capture decisions compare them with the previous registered sample.
//  - Decode table (seg -> nibble): 40->0 79->1 24->2 30->3 19->4 12->5 02->6 78->7 00->8 10->9
//    08->A 03->B 46->C 21->D 06->E 0E->F. 7F->0 with blank=1. Any other -> 0 with err=1.
//  - Per-dwell FSM:
//     WAIT:   an_q is not one-hot-low -> stay. Legal select -> SETTLE with cnt=1.
//     SETTLE: (an_q,seg_q) equal to previous sample -> cnt++.
//             When cnt reaches STABLE_CYCLES, capture into slot k, set seen[k], and go to HELD.
//             A change with a legal select restarts SETTLE with cnt=1. Illegal select -> WAIT.
//     HELD:   no re-capture. A change with a legal select -> SETTLE with cnt=1. Illegal -> WAIT.
//  - Re-capturing a digit already in seen overwrites its slot (the latest pattern wins).
//  - Frame complete when seen becomes all-ones. On the next edge:
//     if !valid_o or ready_i: load value_o/blank_o/err_o from the slots, set valid_o=1, clear seen.
//     else: pulse overrun_o, clear seen, leave outputs and valid_o untouched (the new frame is dropped).
//  - Handshake: valid_o holds with stable data until valid_o & ready_i. valid_o then drops next
//    cycle, unless a completing frame loads in the same cycle (then it stays 1 with new data).
//  - Latency: from the first stable sample of the last digit to valid_o there are
//    STABLE_CYCLES+2 cycles (input register + settle + load).
//  - Counter width: $clog2(STABLE_CYCLES+1). The counter saturates and never wraps.
//  - Reset mid-dwell or mid-frame discards all partial state. No output glitches after reset.
// STRUCTURE
//  - seven_seg_pkg: SEG_0..SEG_F and SEG_BLANK 7-bit constants; dwell_state_t enum {WAIT,SETTLE,HELD}.
//    The encoder and the decoder share these constants.
//  - Sub-module seven_seg_pattern_decoder: combinational, seg[6:0] -> {nibble, blank, err}.
//  - Top level: input registers, dwell FSM + counter, slot/seen registers, output handshake register.
// TESTING
//  1. Scan 4 digits showing 1,2,3,4 (an 1110,1101,1011,0111; each held 6 cycles), ready_i=1
//     -> valid_o 1 cycle, value_o=16'h4321, blank_o=0, err_o=0.
//  2. Digit 2 held only 3 cycles (STABLE_CYCLES=4)
//     -> not captured, no valid_o; the next full scan yields the frame.
//  3. Digit 0 = 7'h7F, digit 1 = 7'h7E, others legal
//     -> blank_o=4'b0001, err_o=4'b0010, nibbles 0 in those slots.
//  4. ready_i=0 over two complete scans showing A,B,C,D then E,F,0,1
//     -> value_o stays 16'hDCBA, overrun_o pulses once. Raise ready_i -> valid_o falls next cycle.
//  5. an_i=4'b1100 (two selects) or 4'b1111 mid-scan
//     -> no capture during it; a stable legal select afterwards captures normally.
//  6. Assert rst after 3 digits captured -> all outputs 0. The next full scan needs all 4 digits.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared 7-segment patterns and dwell FSM state type
package seven_seg_pkg;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        WAIT   = 2'd0,
        SETTLE = 2'd1,
        HELD   = 2'd2
    } dwell_state_t;

endpackage

// File: rtl/seven_seg_pattern_decoder.sv
// rtl/seven_seg_pattern_decoder.sv - combinational segment pattern to hex nibble decoder
module seven_seg_pattern_decoder
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_nibble,
    output logic       o_blank,
    output logic       o_err
);

    // Reverse lookup of the shared encoder table; unknown patterns decode to 0 with err
    always_comb begin
        o_nibble = 4'h0;
        o_blank  = 1'b0;
        o_err    = 1'b0;
        case (i_seg)
            SEG_0:     o_nibble = 4'h0;
            SEG_1:     o_nibble = 4'h1;
            SEG_2:     o_nibble = 4'h2;
            SEG_3:     o_nibble = 4'h3;
            SEG_4:     o_nibble = 4'h4;
            SEG_5:     o_nibble = 4'h5;
            SEG_6:     o_nibble = 4'h6;
            SEG_7:     o_nibble = 4'h7;
            SEG_8:     o_nibble = 4'h8;
            SEG_9:     o_nibble = 4'h9;
            SEG_A:     o_nibble = 4'hA;
            SEG_B:     o_nibble = 4'hB;
            SEG_C:     o_nibble = 4'hC;
            SEG_D:     o_nibble = 4'hD;
            SEG_E:     o_nibble = 4'hE;
            SEG_F:     o_nibble = 4'hF;
            SEG_BLANK: o_blank  = 1'b1;
            default:   o_err    = 1'b1;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// rtl/seven_seg_scan_decoder.sv - decodes a scanned common-anode display bus into hex frames
module seven_seg_scan_decoder
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_i,
    input  logic [NUM_DIGITS-1:0]   an_i,
    output logic [4*NUM_DIGITS-1:0] value_o,
    output logic [NUM_DIGITS-1:0]   blank_o,
    output logic [NUM_DIGITS-1:0]   err_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    overrun_o
);

    localparam int              CW      = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    logic [6:0]              r_seg_q, r_seg_p;
    logic [NUM_DIGITS-1:0]   r_an_q, r_an_p;
    dwell_state_t            r_state;
    logic [CW-1:0]           r_cnt;
    logic [4*NUM_DIGITS-1:0] r_slot_val;
    logic [NUM_DIGITS-1:0]   r_slot_blank, r_slot_err, r_seen;
    logic [4*NUM_DIGITS-1:0] r_value;
    logic [NUM_DIGITS-1:0]   r_blank, r_err;
    logic                    r_valid, r_overrun;

    logic [NUM_DIGITS-1:0]   w_sel;
    logic                    w_legal, w_same, w_capture, w_complete;
    logic [CW-1:0]           w_cnt_next;
    logic [3:0]              w_nib;
    logic                    w_blank, w_err;

    assign w_sel      = ~r_an_q;
    assign w_legal    = $onehot(w_sel);
    assign w_same     = (r_an_q == r_an_p) && (r_seg_q == r_seg_p);
    assign w_cnt_next = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
    assign w_capture  = (r_state == SETTLE) && w_legal && w_same && (w_cnt_next == CNT_MAX);
    assign w_complete = &r_seen;

    seven_seg_pattern_decoder u_dec (
        .i_seg    (r_seg_q),
        .o_nibble (w_nib),
        .o_blank  (w_blank),
        .o_err    (w_err)
    );

    // Register the bus once and keep the previous sample for stability comparison
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seg_q <= '0;
            r_seg_p <= '0;
            r_an_q  <= '0;
            r_an_p  <= '0;
        end else begin
            r_seg_p <= r_seg_q;
            r_an_p  <= r_an_q;
            r_seg_q <= seg_i;
            r_an_q  <= an_i;
        end
    end

    // Dwell FSM: count identical legal samples, capture once per dwell, then hold
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= WAIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                WAIT: begin
                    if (w_legal) begin
                        r_state <= SETTLE;
                        r_cnt   <= CNT_ONE;
                    end
                end
                SETTLE: begin
                    if (!w_legal) begin
                        r_state <= WAIT;
                    end else if (!w_same) begin
                        r_cnt <= CNT_ONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next == CNT_MAX) begin
                            r_state <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (!w_legal) begin
                        r_state <= WAIT;
                    end else if (!w_same) begin
                        r_state <= SETTLE;
                        r_cnt   <= CNT_ONE;
                    end
                end
                default: r_state <= WAIT;
            endcase
        end
    end

    // Slot storage per digit; a completed frame clears the seen mask for the next one
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot_val   <= '0;
            r_slot_blank <= '0;
            r_slot_err   <= '0;
            r_seen       <= '0;
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (w_capture && w_sel[k]) begin
                    r_slot_val[4*k +: 4] <= w_nib;
                    r_slot_blank[k]      <= w_blank;
                    r_slot_err[k]        <= w_err;
                end
            end
            r_seen <= (w_complete ? '0 : r_seen) | (w_capture ? w_sel : '0);
        end
    end

    // Output handshake: load a completed frame when free, otherwise drop it and flag overrun
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value   <= '0;
            r_blank   <= '0;
            r_err     <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_complete) begin
                if (!r_valid || ready_i) begin
                    r_value <= r_slot_val;
                    r_blank <= r_slot_blank;
                    r_err   <= r_slot_err;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && ready_i) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign value_o   = r_value;
    assign blank_o   = r_blank;
    assign err_o     = r_err;
    assign valid_o   = r_valid;
    assign overrun_o = r_overrun;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb/tb_seven_seg_scan_decoder.sv - self-checking bench for seven_seg_scan_decoder
module tb_seven_seg_scan_decoder;

    localparam int ND   = 4;
    localparam int STAB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  seg_i;
    logic [3:0]  an_i;
    logic [15:0] value_o;
    logic [3:0]  blank_o, err_o;
    logic        valid_o, ready_i, overrun_o;

    always #5 clk = ~clk;

    seven_seg_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(STAB)) dut (
        .clk       (clk),
        .rst       (rst),
        .seg_i     (seg_i),
        .an_i      (an_i),
        .value_o   (value_o),
        .blank_o   (blank_o),
        .err_o     (err_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .overrun_o (overrun_o)
    );

    localparam logic [6:0] PAT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [6:0] seg;
        logic [3:0] nib;
        logic       blank;
        logic       err;
    } vec_t;

    vec_t vecs [20];

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;
    bit rand_ready = 0;

    // Reference model: run length of identical samples, captured slots, frame/handshake state
    logic [6:0]  m_prev_seg;
    logic [3:0]  m_prev_an;
    int          m_rl;
    bit          m_have;
    logic [15:0] m_slot_v, m_val;
    logic [3:0]  m_slot_b, m_slot_e, m_blank, m_err, m_seen;
    bit          m_valid, m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++)
            if (s == PAT[i]) return {4'(i), 2'b00};
        if (s == 7'h7F) return 6'b000010;
        return 6'b000001;
    endfunction

    function automatic bit is_legal(input logic [3:0] a);
        return $countones(~a) == 1;
    endfunction

    task automatic model_edge();
        bit         cap;
        int         k;
        logic [5:0] d;
        if (rst) begin
            m_have = 0; m_rl = 0; m_seen = '0; m_slot_v = '0; m_slot_b = '0; m_slot_e = '0;
            m_val = '0; m_blank = '0; m_err = '0; m_valid = 0; m_ovr = 0;
            return;
        end
        cap = m_have && (m_rl == STAB) && is_legal(m_prev_an);
        m_ovr = 0;
        if (m_seen == 4'hF) begin
            if (!m_valid || ready_i) begin
                m_val = m_slot_v; m_blank = m_slot_b; m_err = m_slot_e; m_valid = 1;
            end else begin
                m_ovr = 1;
            end
            m_seen = '0;
        end else if (m_valid && ready_i) begin
            m_valid = 0;
        end
        if (cap) begin
            k = 0;
            for (int i = 0; i < ND; i++) if (!m_prev_an[i]) k = i;
            d = ref_decode(m_prev_seg);
            m_slot_v[4*k +: 4] = d[5:2];
            m_slot_b[k] = d[1];
            m_slot_e[k] = d[0];
            m_seen[k] = 1'b1;
        end
        if (m_have && an_i == m_prev_an && seg_i == m_prev_seg) begin
            if (m_rl < 1000) m_rl++;
        end else begin
            m_rl = 1;
        end
        m_prev_an = an_i;
        m_prev_seg = seg_i;
        m_have = 1;
    endtask

    task automatic tick();
        if (rand_ready) ready_i = 1'($urandom_range(0, 1));
        @(posedge clk);
        model_edge();
        #1;
        if (overrun_o) ovr_cnt++;
        check("model", {6'b0, valid_o, overrun_o, blank_o, err_o, value_o},
                       {6'b0, m_valid, m_ovr, m_blank, m_err, m_val});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic scan_digit(input int k, input logic [6:0] s, input int hold);
        logic [3:0] a;
        a = 4'hF;
        a[k] = 1'b0;
        an_i = a;
        seg_i = s;
        repeat (hold) tick();
    endtask

    task automatic scan_frame(input logic [6:0] p0, input logic [6:0] p1,
                              input logic [6:0] p2, input logic [6:0] p3, input int hold);
        scan_digit(0, p0, hold);
        scan_digit(1, p1, hold);
        scan_digit(2, p2, hold);
        scan_digit(3, p3, hold);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) vecs[i] = '{PAT[i], 4'(i), 1'b0, 1'b0};
        vecs[16] = '{7'h7F, 4'h0, 1'b1, 1'b0};
        vecs[17] = '{7'h7E, 4'h0, 1'b0, 1'b1};
        vecs[18] = '{7'h01, 4'h0, 1'b0, 1'b1};
        vecs[19] = '{7'h55, 4'h0, 1'b0, 1'b1};

        rst = 1'b1; ready_i = 1'b1; an_i = 4'hF; seg_i = 7'h7F;
        tick();
        tick();
        check("reset_outputs", {valid_o, overrun_o, blank_o, err_o, value_o}, 0);
        rst = 1'b0;

        // Basic frame 1,2,3,4
        scan_frame(PAT[1], PAT[2], PAT[3], PAT[4], 6);
        check("t1_valid", valid_o, 1);
        check("t1_value", value_o, 16'h4321);
        check("t1_blank_err", {blank_o, err_o}, 0);
        tick();
        check("t1_valid_drop", valid_o, 0);
        do_reset();

        // Short dwell on digit 2 is not captured
        scan_digit(0, PAT[1], 6);
        scan_digit(1, PAT[2], 6);
        scan_digit(2, PAT[3], 3);
        scan_digit(3, PAT[4], 6);
        check("t2_no_valid", valid_o, 0);
        scan_digit(0, PAT[5], 6);
        scan_digit(1, PAT[6], 6);
        scan_digit(2, PAT[7], 6);
        check("t2_valid", valid_o, 1);
        check("t2_value", value_o, 16'h4765);
        do_reset();

        // Blank and illegal patterns
        scan_frame(7'h7F, 7'h7E, PAT[3], PAT[4], 6);
        check("t3_value", value_o, 16'h4300);
        check("t3_blank", blank_o, 4'b0001);
        check("t3_err", err_o, 4'b0010);
        do_reset();

        // Back-pressure: second frame dropped with one overrun pulse
        ready_i = 1'b0;
        scan_frame(PAT[10], PAT[11], PAT[12], PAT[13], 6);
        check("t4_valid", valid_o, 1);
        check("t4_value", value_o, 16'hDCBA);
        ovr_cnt = 0;
        scan_frame(PAT[14], PAT[15], PAT[0], PAT[1], 6);
        check("t4_overrun_count", ovr_cnt, 1);
        check("t4_value_held", value_o, 16'hDCBA);
        check("t4_valid_held", valid_o, 1);
        ready_i = 1'b1;
        tick();
        check("t4_valid_drop", valid_o, 0);
        do_reset();

        // Illegal selects mid-scan do not capture
        scan_digit(0, PAT[1], 6);
        scan_digit(1, PAT[2], 6);
        scan_digit(2, PAT[3], 6);
        an_i = 4'b1100; seg_i = PAT[9];
        repeat (6) tick();
        an_i = 4'b1111;
        repeat (6) tick();
        check("t5_no_valid", valid_o, 0);
        scan_digit(3, PAT[4], 6);
        check("t5_valid", valid_o, 1);
        check("t5_value", value_o, 16'h4321);
        do_reset();

        // Reset mid-frame discards everything
        ready_i = 1'b0;
        scan_frame(PAT[1], PAT[2], PAT[3], PAT[4], 6);
        scan_digit(0, PAT[5], 6);
        scan_digit(1, PAT[6], 6);
        scan_digit(2, PAT[7], 6);
        rst = 1'b1;
        tick();
        check("t6_reset_outputs", {valid_o, overrun_o, blank_o, err_o, value_o}, 0);
        tick();
        rst = 1'b0;
        ready_i = 1'b1;
        scan_digit(0, PAT[5], 6);
        scan_digit(1, PAT[6], 6);
        scan_digit(2, PAT[7], 6);
        check("t6_partial_no_valid", valid_o, 0);
        scan_digit(3, PAT[8], 6);
        check("t6_valid", valid_o, 1);
        check("t6_value", value_o, 16'h8765);
        do_reset();

        // Table-driven decode of every pattern in digit 0
        for (int i = 0; i < 20; i++) begin
            scan_frame(vecs[i].seg, PAT[1], PAT[2], PAT[3], 6);
            check($sformatf("vec%0d", i), {valid_o, value_o, blank_o[0], err_o[0]},
                  {1'b1, 12'h321, vecs[i].nib, vecs[i].blank, vecs[i].err});
        end

        // Randomized dwells against the reference model
        rand_ready = 1;
        for (int n = 0; n < 400; n++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_reset();
            end else begin
                if (r < 75) begin
                    an_i = 4'hF;
                    an_i[n % 4] = 1'b0;
                end else begin
                    an_i = 4'($urandom_range(0, 15));
                end
                r = int'($urandom_range(0, 99));
                if (r < 80)      seg_i = PAT[$urandom_range(0, 15)];
                else if (r < 90) seg_i = 7'h7F;
                else             seg_i = 7'($urandom_range(0, 127));
                repeat ($urandom_range(1, 7)) tick();
            end
        end
        rand_ready = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
